// File: rtl/simon_draw_pkg.sv
// -----------------------------------------------------------------------------
// simon_draw_pkg
// Shared constants for the Simon Says tile drawing path:
//   - tile IDs (board position / colour name)
//   - lit palette colours (3-bit RGB)
//   - FSM state encoding of the tile draw controller
//   - datapath sweep length and block side
//   - request struct and the lit-colour lookup helper
// -----------------------------------------------------------------------------
package simon_draw_pkg;

    // Tile IDs: bit 0 selects the right column, bit 1 selects the bottom row.
    localparam logic [1:0] TILE_GREEN  = 2'd0;
    localparam logic [1:0] TILE_RED    = 2'd1;
    localparam logic [1:0] TILE_YELLOW = 2'd2;
    localparam logic [1:0] TILE_BLUE   = 2'd3;

    // Lit palette, 3-bit {R,G,B}.
    localparam logic [2:0] PAL_GREEN  = 3'b010;
    localparam logic [2:0] PAL_RED    = 3'b100;
    localparam logic [2:0] PAL_YELLOW = 3'b110;
    localparam logic [2:0] PAL_BLUE   = 3'b001;

    // Controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The datapath sweeps a 4x4 block in 16 cycles.
    localparam int SWEEP_LEN = 16;
    localparam int BLK_SIDE  = 4;

    typedef struct packed {
        logic [1:0] tile;
        logic       lit;
    } draw_req_t;

    function automatic logic [2:0] lit_colour(input logic [1:0] tile);
        logic [2:0] c;
        case (tile)
            TILE_GREEN:  c = PAL_GREEN;
            TILE_RED:    c = PAL_RED;
            TILE_YELLOW: c = PAL_YELLOW;
            TILE_BLUE:   c = PAL_BLUE;
            default:     c = PAL_GREEN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/simon_tile_draw_ctrl_if.sv
// -----------------------------------------------------------------------------
// simon_tile_draw_ctrl_if
// Request handshake between game logic and the tile draw controller.
//   req_valid  requester -> controller  request present
//   req_ready  controller -> requester  controller can accept
//   req_tile   requester -> controller  tile ID (0 green .. 3 blue)
//   req_lit    requester -> controller  1 = palette colour, 0 = dim colour
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface simon_tile_draw_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_tile;
    logic       req_lit;

    modport master (
        output req_valid,
        output req_tile,
        output req_lit,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_tile,
        input  req_lit,
        output req_ready
    );

endinterface

// File: rtl/simon_tile_lut.sv
// -----------------------------------------------------------------------------
// simon_tile_lut
// Combinational map from (tile, lit) to the tile's top-left pixel and the
// colour to paint it with. Shared with the full-board redraw sequencer.
//   tile    in   2  tile ID
//   lit     in   1  1 = palette colour, 0 = DIM_COLOUR
//   org_x   out  8  tile top-left x (pixels, truncated to 8 bits)
//   org_y   out  7  tile top-left y (pixels, truncated to 7 bits)
//   colour  out  3  resolved colour
// -----------------------------------------------------------------------------
module simon_tile_lut
    import simon_draw_pkg::*;
#(
    parameter int         X0         = 56,
    parameter int         Y0         = 36,
    parameter int         GAP        = 16,
    parameter int         BLK_X      = 4,
    parameter int         BLK_Y      = 4,
    parameter logic [2:0] DIM_COLOUR = 3'b000
) (
    input  logic [1:0] tile,
    input  logic       lit,
    output logic [7:0] org_x,
    output logic [6:0] org_y,
    output logic [2:0] colour
);

    localparam int W = BLK_SIDE * BLK_X;
    localparam int H = BLK_SIDE * BLK_Y;

    localparam logic [7:0] X_LEFT   = 8'(X0);
    localparam logic [7:0] X_RIGHT  = 8'(X0 + W + GAP);
    localparam logic [6:0] Y_TOP    = 7'(Y0);
    localparam logic [6:0] Y_BOTTOM = 7'(Y0 + H + GAP);

    // Tile position: green/red on the top row, yellow/blue on the bottom row.
    always_comb begin
        org_x = X_LEFT;
        org_y = Y_TOP;
        case (tile)
            TILE_GREEN:  begin org_x = X_LEFT;  org_y = Y_TOP;    end
            TILE_RED:    begin org_x = X_RIGHT; org_y = Y_TOP;    end
            TILE_YELLOW: begin org_x = X_LEFT;  org_y = Y_BOTTOM; end
            TILE_BLUE:   begin org_x = X_RIGHT; org_y = Y_BOTTOM; end
            default:     begin org_x = X_LEFT;  org_y = Y_TOP;    end
        endcase
    end

    // Colour: palette entry when lit, otherwise the erase colour.
    always_comb begin
        colour = DIM_COLOUR;
        if (lit) begin
            colour = lit_colour(tile);
        end else begin
            colour = DIM_COLOUR;
        end
    end

endmodule

// File: rtl/simon_tile_draw_ctrl.sv
// -----------------------------------------------------------------------------
// simon_tile_draw_ctrl
// Sequencer in front of the 4x4-block pixel datapath. Takes one "paint tile N
// lit/unlit" request, holds the datapath counter at phase 0 for one SYNC cycle,
// then steps the block origin across the tile, one origin per 16-cycle sweep,
// and pulses done when the last block has been plotted.
//   clk        in   1  clock, rising edge
//   resetn     in   1  synchronous active-low reset
//   req        if      request handshake (slave modport)
//   dp_resetn  out  1  active-low reset to the datapath counter
//   x_org      out  8  block origin x
//   y_org      out  7  block origin y
//   colour     out  3  colour to datapath
//   plot       out  1  VGA write enable
//   busy       out  1  high outside IDLE
//   done       out  1  one-cycle pulse when the tile is complete
// -----------------------------------------------------------------------------
module simon_tile_draw_ctrl
    import simon_draw_pkg::*;
#(
    parameter int         X0         = 56,
    parameter int         Y0         = 36,
    parameter int         GAP        = 16,
    parameter int         BLK_X      = 4,
    parameter int         BLK_Y      = 4,
    parameter logic [2:0] DIM_COLOUR = 3'b000
) (
    input  logic                    clk,
    input  logic                    resetn,
    simon_tile_draw_ctrl_if.slave   req,
    output logic                    dp_resetn,
    output logic [7:0]              x_org,
    output logic [6:0]              y_org,
    output logic [2:0]              colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam int BXW = (BLK_X > 1) ? $clog2(BLK_X) : 1;
    localparam int BYW = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;

    localparam logic [BXW-1:0] BX_LAST    = BXW'(BLK_X - 1);
    localparam logic [BYW-1:0] BY_LAST    = BYW'(BLK_Y - 1);
    localparam logic [3:0]     PHASE_LAST = 4'(SWEEP_LEN - 1);
    localparam logic [7:0]     X_STEP     = 8'(BLK_SIDE);
    localparam logic [6:0]     Y_STEP     = 7'(BLK_SIDE);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    draw_req_t      req_r;
    logic [3:0]     phase_r;
    logic [BXW-1:0] bx_r;
    logic [BYW-1:0] by_r;
    logic [7:0]     x_org_r;
    logic [6:0]     y_org_r;
    logic [2:0]     colour_r;
    logic           plot_r;
    logic           busy_r;
    logic           done_r;

    logic           accept_s;
    logic           last_blk_s;
    logic [7:0]     tile_x_s;
    logic [6:0]     tile_y_s;
    logic [2:0]     tile_colour_s;

    simon_tile_lut #(
        .X0         (X0),
        .Y0         (Y0),
        .GAP        (GAP),
        .BLK_X      (BLK_X),
        .BLK_Y      (BLK_Y),
        .DIM_COLOUR (DIM_COLOUR)
    ) u_lut (
        .tile   (req_r.tile),
        .lit    (req_r.lit),
        .org_x  (tile_x_s),
        .org_y  (tile_y_s),
        .colour (tile_colour_s)
    );

    // The datapath counter is also held in reset while our own reset is low.
    assign req.req_ready = (state_r == ST_IDLE) && resetn;
    assign dp_resetn     = resetn && (state_r != ST_SYNC);

    assign accept_s   = req.req_valid && req.req_ready;
    assign last_blk_s = (phase_r == PHASE_LAST) && (bx_r == BX_LAST) && (by_r == BY_LAST);

    assign x_org  = x_org_r;
    assign y_org  = y_org_r;
    assign colour = colour_r;
    assign plot   = plot_r;
    assign busy   = busy_r;
    assign done   = done_r;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNC: state_nxt_s = ST_DRAW;
            ST_DRAW: begin
                if (last_blk_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAW;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            plot_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            plot_r  <= (state_nxt_s == ST_DRAW);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Request latch; the LUT works from the latched copy for the whole tile.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_r <= '0;
        end else if (accept_s) begin
            req_r.tile <= req.req_tile;
            req_r.lit  <= req.req_lit;
        end else begin
            req_r <= req_r;
        end
    end

    // Block walker. phase_r shadows the datapath counter, which SYNC forces to
    // 0, so each origin change lands exactly on a sweep boundary. The final
    // block does not advance, leaving its origin on the outputs afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_r  <= 4'd0;
            bx_r     <= '0;
            by_r     <= '0;
            x_org_r  <= 8'd0;
            y_org_r  <= 7'd0;
            colour_r <= 3'd0;
        end else if (state_r == ST_SYNC) begin
            phase_r  <= 4'd0;
            bx_r     <= '0;
            by_r     <= '0;
            x_org_r  <= tile_x_s;
            y_org_r  <= tile_y_s;
            colour_r <= tile_colour_s;
        end else if (state_r == ST_DRAW) begin
            phase_r <= phase_r + 4'd1;
            if ((phase_r == PHASE_LAST) && !last_blk_s) begin
                if (bx_r == BX_LAST) begin
                    bx_r    <= '0;
                    x_org_r <= tile_x_s;
                    by_r    <= by_r + BYW'(1);
                    y_org_r <= y_org_r + Y_STEP;
                end else begin
                    bx_r    <= bx_r + BXW'(1);
                    x_org_r <= x_org_r + X_STEP;
                end
            end else begin
                bx_r    <= bx_r;
                by_r    <= by_r;
                x_org_r <= x_org_r;
                y_org_r <= y_org_r;
            end
        end else begin
            phase_r  <= phase_r;
            bx_r     <= bx_r;
            by_r     <= by_r;
            x_org_r  <= x_org_r;
            y_org_r  <= y_org_r;
            colour_r <= colour_r;
        end
    end

endmodule

// File: tb/tb_simon_tile_draw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_tile_draw_ctrl
// Self-checking bench: drives tile requests through the interface, models the
// 4x4 datapath counter to reconstruct plotted pixels, and compares timing,
// origins, colours and pixel coverage against values computed from the tile
// geometry (X0=56, Y0=36, 16-pixel tiles, 16-pixel gap).
// -----------------------------------------------------------------------------
module tb_simon_tile_draw_ctrl;

    typedef struct packed {
        int x;
        int y;
    } px_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       dp_resetn;
    logic [7:0] x_org;
    logic [6:0] y_org;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    // Datapath model and observation state.
    logic [3:0] dp_cnt = 4'd0;
    int         cyc    = 0;
    px_t        px_q[$];
    int         sync_q[$];

    simon_tile_draw_ctrl_if req_if();

    simon_tile_draw_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req_if),
        .dp_resetn (dp_resetn),
        .x_org     (x_org),
        .y_org     (y_org),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Datapath model: counter cleared by dp_resetn, pixel = origin + counter offsets.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (plot) begin
            px_q.push_back('{x: int'(x_org) + int'(dp_cnt[1:0]), y: int'(y_org) + int'(dp_cnt[3:2])});
        end
        if (resetn && !dp_resetn) begin
            sync_q.push_back(cyc);
        end
        if (!dp_resetn) begin
            dp_cnt <= 4'd0;
        end else begin
            dp_cnt <= dp_cnt + 4'd1;
        end
    end

    function automatic int exp_x(input logic [1:0] t);
        return 56 + (t[0] ? 32 : 0);
    endfunction

    function automatic int exp_y(input logic [1:0] t);
        return 36 + (t[1] ? 32 : 0);
    endfunction

    function automatic int exp_colour(input logic [1:0] t, input logic l);
        int pal[4] = '{2, 4, 6, 1};
        return l ? pal[t] : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full request: called at a falling edge in IDLE, returns at the falling
    // edge of the IDLE cycle after done.
    task automatic draw_tile(input logic [1:0] t, input logic l, input bit keep,
                             input logic [1:0] nt, input logic nl,
                             input int pulse_at, input int hold_at, input logic [1:0] ht);
        int  tx;
        int  ty;
        int  start;
        int  bad;
        int  cells;
        int  grid [16][16];
        px_t p;
        tx = exp_x(t);
        ty = exp_y(t);
        bad = 0;
        cells = 0;
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) grid[i][j] = 0;
        req_if.req_valid = 1'b1;
        req_if.req_tile  = t;
        req_if.req_lit   = l;
        chk("idle_ready", 32'(req_if.req_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        start = px_q.size();
        @(negedge clk);
        chk("sync_dp_resetn", 32'(dp_resetn), 0);
        chk("sync_busy", 32'(busy), 1);
        chk("sync_plot", 32'(plot), 0);
        chk("sync_ready", 32'(req_if.req_ready), 0);
        if (!keep) req_if.req_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            chk("draw_plot", 32'(plot), 1);
            chk("draw_dp_resetn", 32'(dp_resetn), 1);
            chk("draw_busy", 32'(busy), 1);
            chk("draw_done", 32'(done), 0);
            chk("draw_ready", 32'(req_if.req_ready), 0);
            chk("draw_x_org", 32'(x_org), 32'(tx + 4 * ((k / 16) % 4)));
            chk("draw_y_org", 32'(y_org), 32'(ty + 4 * (k / 64)));
            chk("draw_colour", 32'(colour), 32'(exp_colour(t, l)));
            if (k == pulse_at) begin
                req_if.req_valid = 1'b1;
                req_if.req_tile  = 2'd1;
                req_if.req_lit   = 1'b1;
            end
            if (pulse_at >= 0 && k == pulse_at + 1) req_if.req_valid = 1'b0;
            if (k == hold_at) begin
                req_if.req_valid = 1'b1;
                req_if.req_tile  = ht;
                req_if.req_lit   = 1'b1;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        chk("done_plot", 32'(plot), 0);
        chk("done_busy", 32'(busy), 1);
        if (keep) begin
            req_if.req_tile = nt;
            req_if.req_lit  = nl;
        end
        for (int i = start; i < px_q.size(); i++) begin
            p = px_q[i];
            if (p.x >= tx && p.x < tx + 16 && p.y >= ty && p.y < ty + 16) grid[p.x - tx][p.y - ty]++;
            else bad++;
        end
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) if (grid[i][j] != 1) cells++;
        chk("pix_outside", 32'(bad), 0);
        chk("pix_once", 32'(cells), 0);
        chk("plot_count", 32'(px_q.size() - start), 256);
        if (px_q.size() > start) begin
            p = px_q[px_q.size() - 1];
            chk("last_px_x", 32'(p.x), 32'(tx + 15));
            chk("last_px_y", 32'(p.y), 32'(ty + 15));
        end
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_plot", 32'(plot), 0);
        chk("post_ready", 32'(req_if.req_ready), 1);
    endtask

    initial begin
        logic [1:0] cur;
        logic [1:0] nt;
        logic       cl;
        logic       nl;
        int         s0;

        resetn           = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_tile  = 2'd0;
        req_if.req_lit   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_x_org", 32'(x_org), 0);
        chk("rst_y_org", 32'(y_org), 0);
        chk("rst_colour", 32'(colour), 0);
        chk("rst_dp_resetn", 32'(dp_resetn), 0);
        chk("rst_ready", 32'(req_if.req_ready), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(req_if.req_ready), 1);
        chk("rel_dp_resetn", 32'(dp_resetn), 1);

        // Tile0 lit; a held tile2 request arrives mid-draw.
        draw_tile(2'd0, 1'b1, 1'b0, 2'd0, 1'b0, -1, int'($urandom_range(10, 200)), 2'd2);
        // Held tile2 is served straight away; a 1-cycle tile1 pulse mid-draw is lost.
        draw_tile(2'd2, 1'b1, 1'b0, 2'd0, 1'b0, int'($urandom_range(10, 200)), -1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lost_pulse_busy", 32'(busy), 0);
            chk("lost_pulse_dp_resetn", 32'(dp_resetn), 1);
        end

        // Tile3 unlit.
        draw_tile(2'd3, 1'b0, 1'b0, 2'd0, 1'b0, -1, -1, 2'd0);

        // Reset during block 5 of a tile2 draw.
        req_if.req_valid = 1'b1;
        req_if.req_tile  = 2'd2;
        req_if.req_lit   = 1'b1;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        repeat (16 * 5 + 3) @(negedge clk);
        chk("mid_plot_before", 32'(plot), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_plot", 32'(plot), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_x_org", 32'(x_org), 0);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rel_done", 32'(done), 0);
            chk("mid_rel_busy", 32'(busy), 0);
        end
        draw_tile(2'd1, 1'b1, 1'b0, 2'd0, 1'b0, -1, -1, 2'd0);

        // Back-to-back with random alternating tiles and random lit.
        s0  = sync_q.size();
        cur = 2'($urandom_range(0, 3));
        cl  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) begin
            nt = cur + 2'(1 + $urandom_range(0, 2));
            nl = 1'($urandom_range(0, 1));
            draw_tile(cur, cl, (i < 4), nt, nl, -1, -1, 2'd0);
            cur = nt;
            cl  = nl;
        end
        chk("b2b_sync_count", 32'(sync_q.size() - s0), 5);
        if (sync_q.size() >= s0 + 5) begin
            for (int i = 1; i < 5; i++) begin
                chk("b2b_period", 32'(sync_q[s0 + i] - sync_q[s0 + i - 1]), 259);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
